// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants, types and helpers for the 7-segment scan controller.
// Functions are sized for the largest supported display (8 digits).
package ssd_scan_ctrl_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef struct packed {
    logic [NIBBLE_W-1:0] nib;
    logic                dp;
    logic                fd;
  } slot_out_t;

  function automatic logic [MAX_DIGITS-1:0] onehot(
    input logic [2:0] idx
  );
    onehot = MAX_DIGITS'(1) << idx;
  endfunction

  // Bit k set when digit k is a leading zero that may be blanked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [NIBBLE_W*MAX_DIGITS-1:0] value,
    input logic [MAX_DIGITS-1:0]          dp,
    input int                             n
  );
    logic keep;
    keep    = 1'b0;
    lz_mask = '0;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      if (k < n) begin
        if (value[NIBBLE_W*k +: NIBBLE_W] != '0 || dp[k])
          keep = 1'b1;
        lz_mask[k] = !keep && (k != 0);
      end
    end
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Host-side load bus plus the display drive outputs.
// master = host/display side, slave = scan controller.
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    A;
  logic                    B;
  logic                    C;
  logic                    D;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output load, value, dp_mask,
    input  A, B, C, D, dp_out,
    input  digit_sel, frame_done
  );

  modport slave (
    input  load, value, dp_mask,
    output A, B, C, D, dp_out,
    output digit_sel, frame_done
  );

endinterface

// File: rtl/ssd_scan_ctrl_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 per digit slot.
// in_blank looks at the next count so outputs can be registered.
module ssd_tick_gen #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end,
  output logic in_blank
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next count and slot flags.
  always_comb begin
    slot_end = (cnt == CW'(DIV - 1));
    cnt_nxt  = slot_end ? '0 : cnt + 1'b1;
    in_blank = (cnt_nxt < CW'(BLANK));
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-aligned commits.
// Outputs are registered from next-state so they line up with idx/cnt.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int LZS_EN      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ssd_scan_ctrl_if.slave  bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = NIBBLE_W * NUM_DIGITS;

  logic                  slot_end;
  logic                  in_blank;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic                  last;
  logic                  wrap;
  logic [VW-1:0]         pend_v;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pending_v;
  logic                  pending_v_nxt;
  logic [VW-1:0]         shad_v;
  logic [VW-1:0]         shad_v_nxt;
  logic [NUM_DIGITS-1:0] shad_dp;
  logic [NUM_DIGITS-1:0] shad_dp_nxt;
  logic [NUM_DIGITS-1:0] sup;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [NUM_DIGITS-1:0] sel_r;
  slot_out_t             out_nxt;
  slot_out_t             out_r;

  ssd_tick_gen #(
    .DIV   (REFRESH_DIV),
    .BLANK (BLANK_CYC)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_end (slot_end),
    .in_blank (in_blank)
  );

  // Next digit index, shadow commit and output image.
  always_comb begin
    last          = (idx == IW'(NUM_DIGITS - 1));
    wrap          = slot_end && last;
    idx_nxt       = idx;
    shad_v_nxt    = shad_v;
    shad_dp_nxt   = shad_dp;
    pending_v_nxt = pending_v;
    if (slot_end)
      idx_nxt = last ? '0 : idx + 1'b1;
    if (wrap && bus.load) begin
      shad_v_nxt    = bus.value;
      shad_dp_nxt   = bus.dp_mask;
      pending_v_nxt = 1'b0;
    end else if (wrap && pending_v) begin
      shad_v_nxt    = pend_v;
      shad_dp_nxt   = pend_dp;
      pending_v_nxt = 1'b0;
    end else if (bus.load) begin
      pending_v_nxt = 1'b1;
    end
    sup = '0;
    if (LZS_EN != 0)
      sup = NUM_DIGITS'(lz_mask(
        (NIBBLE_W*MAX_DIGITS)'(shad_v_nxt),
        MAX_DIGITS'(shad_dp_nxt), NUM_DIGITS));
    sel_nxt = NUM_DIGITS'(onehot(3'(idx_nxt)));
    if (in_blank || sup[idx_nxt])
      sel_nxt = '0;
    out_nxt.nib = shad_v_nxt[NIBBLE_W*idx_nxt +: NIBBLE_W];
    out_nxt.dp  = shad_dp_nxt[idx_nxt];
    out_nxt.fd  = wrap;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      pend_v    <= '0;
      pend_dp   <= '0;
      pending_v <= 1'b0;
      shad_v    <= '0;
      shad_dp   <= '0;
      sel_r     <= '0;
      out_r     <= '0;
    end else begin
      idx       <= idx_nxt;
      pending_v <= pending_v_nxt;
      shad_v    <= shad_v_nxt;
      shad_dp   <= shad_dp_nxt;
      sel_r     <= sel_nxt;
      out_r     <= out_nxt;
      if (bus.load) begin
        pend_v  <= bus.value;
        pend_dp <= bus.dp_mask;
      end
    end
  end

  assign bus.A          = out_r.nib[3];
  assign bus.B          = out_r.nib[2];
  assign bus.C          = out_r.nib[1];
  assign bus.D          = out_r.nib[0];
  assign bus.dp_out     = out_r.dp;
  assign bus.frame_done = out_r.fd;
  assign bus.digit_sel  = sel_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: 4 digits, 8-cycle slots, 2-cycle blank.
// Two instances: leading-zero suppression on (dut0) and off (dut1).
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] nib;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  ssd_scan_ctrl_if #(.NUM_DIGITS(4)) bus0 ();
  ssd_scan_ctrl_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus0.load    = load;
  assign bus0.value   = value;
  assign bus0.dp_mask = dp_mask;
  assign bus1.load    = load;
  assign bus1.value   = value;
  assign bus1.dp_mask = dp_mask;

  ssd_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8),
    .BLANK_CYC(2), .LZS_EN(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  ssd_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8),
    .BLANK_CYC(2), .LZS_EN(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic get(
    input  bit         which,
    output logic [3:0] sel,
    output logic [3:0] nib,
    output logic       dp,
    output logic       fd
  );
    if (which) begin
      sel = bus1.digit_sel;
      nib = {bus1.A, bus1.B, bus1.C, bus1.D};
      dp  = bus1.dp_out;
      fd  = bus1.frame_done;
    end else begin
      sel = bus0.digit_sel;
      nib = {bus0.A, bus0.B, bus0.C, bus0.D};
      dp  = bus0.dp_out;
      fd  = bus0.frame_done;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value   = v;
    dp_mask = dp;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Expected frame from the display rules: a digit k>=1 is dark when
  // it and every digit above it are zero with no decimal point.
  task automatic push_frame(
    input logic [15:0] v,
    input logic [3:0]  dp,
    input bit          lzs
  );
    exp_t e;
    logic [15:0] vh;
    logic [3:0]  dh;
    for (int s = 0; s < 4; s++) begin
      vh    = v >> (4 * s);
      dh    = dp >> s;
      e.nib = vh[3:0];
      e.dp  = dh[0];
      if (!lzs || s == 0 || vh != 0 || dh != 0)
        e.sel = 4'b0001 << s;
      else
        e.sel = 4'b0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_fd(input bit which);
    logic [3:0] sel, nib;
    logic dp, fd;
    bit ok;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      get(which, sel, nib, dp, fd);
      if (fd === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL wait_fd: no frame_done within 80 cycles (dut%0d)",
               which);
    end
  endtask

  // Called on the negedge where frame_done is high; walks one frame.
  task automatic check_frame(input bit which);
    logic [3:0] sel, nib;
    logic dp, fd;
    exp_t e;
    int s, c;
    e.sel = 'x; e.nib = 'x; e.dp = 'x;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      s = k / 8;
      c = k % 8;
      get(which, sel, nib, dp, fd);
      if (c == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: empty queue slot %0d", s);
        end else begin
          e = exp_q.pop_front();
        end
        checks++;
        if (sel !== 4'b0000) begin
          errors++;
          $display("FAIL blank_sel d%0d s%0d: got %b want 0000",
                   which, s, sel);
        end
        checks++;
        if (nib !== e.nib) begin
          errors++;
          $display("FAIL blank_nib d%0d s%0d: got %h want %h",
                   which, s, nib, e.nib);
        end
      end
      if (k == 1) begin
        checks++;
        if (fd !== 1'b0) begin
          errors++;
          $display("FAIL fd_pulse d%0d: got %b want 0", which, fd);
        end
      end
      if (c == 2 || c == 7) begin
        checks++;
        if (sel !== e.sel || nib !== e.nib || dp !== e.dp) begin
          errors++;
          $display("FAIL slot d%0d s%0d c%0d: got %b/%h/%b want %b/%h/%b",
                   which, s, c, sel, nib, dp, e.sel, e.nib, e.dp);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] sel, nib;
    logic dp, fd;
    int on_n, off_n, fd_n;
    repeat (3) begin
      @(negedge clk);
      get(0, sel, nib, dp, fd);
      checks++;
      if (sel !== 0 || nib !== 0 || dp !== 0 || fd !== 0) begin
        errors++;
        $display("FAIL reset_hold: got %b/%h/%b/%b want 0/0/0/0",
                 sel, nib, dp, fd);
      end
    end
    rst_n = 1'b1;
    on_n = -1; off_n = -1; fd_n = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      get(0, sel, nib, dp, fd);
      if (on_n < 0 && sel == 4'b0001) on_n = n;
      if (on_n > 0 && off_n < 0 && sel == 4'b0000) off_n = n;
      if (fd_n < 0 && fd === 1'b1) fd_n = n;
    end
    checks++;
    if (on_n != 2) begin
      errors++;
      $display("FAIL first_enable: got %0d want 2", on_n);
    end
    checks++;
    if (off_n != 8) begin
      errors++;
      $display("FAIL slot_period: got %0d want 8", off_n);
    end
    checks++;
    if (fd_n != 32) begin
      errors++;
      $display("FAIL first_frame_done: got %0d want 32", fd_n);
    end
  endtask

  task automatic test_load();
    do_load(16'h12AF, 4'b0100);
    push_frame(16'h12AF, 4'b0100, 1);
    wait_fd(0);
    check_frame(0);
  endtask

  task automatic test_lzs();
    do_load(16'h0042, 4'b0000);
    push_frame(16'h0042, 4'b0000, 1);
    wait_fd(0);
    check_frame(0);
    push_frame(16'h0042, 4'b0000, 0);
    wait_fd(1);
    check_frame(1);
    do_load(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000, 1);
    wait_fd(0);
    check_frame(0);
    do_load(16'h0000, 4'b1000);
    push_frame(16'h0000, 4'b1000, 1);
    wait_fd(0);
    check_frame(0);
  endtask

  task automatic test_tear();
    logic [3:0] sel, nib;
    logic dp, fd;
    do_load(16'h5678, 4'b0000);
    push_frame(16'h5678, 4'b0000, 1);
    wait_fd(0);
    check_frame(0);
    wait_fd(0);
    repeat (9) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (8) @(negedge clk);
    get(0, sel, nib, dp, fd);
    checks++;
    if (sel !== 4'b0100 || nib !== 4'h6) begin
      errors++;
      $display("FAIL tear_slot2: got %b/%h want 0100/6", sel, nib);
    end
    do_load(16'h2222, 4'b0000);
    repeat (7) @(negedge clk);
    get(0, sel, nib, dp, fd);
    checks++;
    if (sel !== 4'b1000 || nib !== 4'h5) begin
      errors++;
      $display("FAIL tear_slot3: got %b/%h want 1000/5", sel, nib);
    end
    push_frame(16'h2222, 4'b0000, 1);
    wait_fd(0);
    check_frame(0);
  endtask

  task automatic test_wrap_load();
    logic [3:0] sel, nib;
    logic dp, fd;
    do_load(16'h3333, 4'b0000);
    push_frame(16'h3333, 4'b0000, 1);
    get(0, sel, nib, dp, fd);
    checks++;
    if (fd !== 1'b1) begin
      errors++;
      $display("FAIL wrap_fd: got %b want 1", fd);
    end
    check_frame(0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] sel, nib;
    logic dp, fd;
    wait_fd(0);
    repeat (10) @(negedge clk);
    do_load(16'h7777, 4'b1111);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      get(w[0], sel, nib, dp, fd);
      checks++;
      if (sel !== 0 || nib !== 0 || dp !== 0 || fd !== 0) begin
        errors++;
        $display("FAIL mid_reset d%0d: got %b/%h/%b/%b want 0/0/0/0",
                 w, sel, nib, dp, fd);
      end
    end
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, 1);
    wait_fd(0);
    check_frame(0);
    push_frame(16'h0000, 4'b0000, 1);
    wait_fd(0);
    check_frame(0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_lzs();
    test_tear();
    test_wrap_load();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
